// File: rtl/serial_mod_pkg.sv
// Shared definitions for the bit-serial modulo checker: divisor bounds, remainder width
// and the single conditional-subtract reduction step.
package serial_mod_pkg;

  localparam int unsigned MIN_DIVISOR = 2;
  localparam int unsigned MAX_DIVISOR = 255;

  // Bits needed to hold any remainder 0..divisor-1.
  function automatic int unsigned rem_width(input int unsigned divisor);
    return $clog2(divisor);
  endfunction

  // Reduce a value known to be < 2*divisor into 0..divisor-1 with one compare/subtract.
  // 9 bits covers 2*MAX_DIVISOR-1.
  function automatic logic [8:0] mod_reduce(input logic [8:0] value, input logic [8:0] divisor);
    return (value >= divisor) ? (value - divisor) : value;
  endfunction

endpackage

// File: rtl/mod_add_reduce.sv
// (a + b + cin) mod DIVISOR for a, b < DIVISOR. The sum never reaches 2*DIVISOR, so a
// single conditional subtract at W+1 bits is a complete reduction.
module mod_add_reduce
  import serial_mod_pkg::*;
#(
  parameter int unsigned DIVISOR = 3,
  parameter int unsigned W       = rem_width(DIVISOR)
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o
);

  logic [W:0] sum;

  // Widen by one bit, add, then fold back into range.
  always_comb begin
    sum   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    sum_o = W'(mod_reduce(9'(sum), 9'(DIVISOR)));
  end

endmodule

// File: rtl/serial_mod_n_checker.sv
// Bit-serial divisibility checker: keeps a running remainder modulo DIVISOR (2..255) of a
// number arriving one bit per valid beat, MSB-first or LSB-first, and captures a result on
// the end-of-number beat.
// Optional macro SERIAL_MOD_REM_OUT_EN exposes the running and captured remainders.
module serial_mod_n_checker
  import serial_mod_pkg::*;
#(
  parameter int unsigned DIVISOR   = 3,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned REM_W     = rem_width(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             x_i,
  input  logic             valid_i,
  input  logic             sop_i,
  input  logic             eop_i,
  output logic             div_o,
  output logic             res_valid_o,
  output logic             res_div_o
`ifdef SERIAL_MOD_REM_OUT_EN
  ,
  output logic [REM_W-1:0] rem_o,
  output logic [REM_W-1:0] res_rem_o
`endif
);

  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_next;
  logic [REM_W-1:0] base;
  logic             res_valid_q;
  logic             res_div_q;

  // sop restarts the number from an empty (zero) accumulation.
  always_comb begin
    base = sop_i ? '0 : rem_q;
  end

  if (MSB_FIRST) begin : g_msb
    // rem = (2*base + x) mod DIVISOR: doubling and the new bit fold into one reduction.
    mod_add_reduce #(
      .DIVISOR(DIVISOR),
      .W      (REM_W)
    ) u_rem_add (
      .a_i  (base),
      .b_i  (base),
      .cin_i(x_i),
      .sum_o(rem_next)
    );
  end else begin : g_lsb
    logic [REM_W-1:0] wt_q;
    logic [REM_W-1:0] wt_next;
    logic [REM_W-1:0] w;
    logic [REM_W-1:0] addend;

    // Weight of the current bit is 2^k mod DIVISOR; sop restarts it at bit 0.
    always_comb begin
      w      = sop_i ? REM_W'(1) : wt_q;
      addend = x_i ? w : '0;
    end

    mod_add_reduce #(
      .DIVISOR(DIVISOR),
      .W      (REM_W)
    ) u_rem_add (
      .a_i  (base),
      .b_i  (addend),
      .cin_i(1'b0),
      .sum_o(rem_next)
    );

    // Power-of-two divisors drive this to 0 and it stays there, which is correct.
    mod_add_reduce #(
      .DIVISOR(DIVISOR),
      .W      (REM_W)
    ) u_wt_add (
      .a_i  (w),
      .b_i  (w),
      .cin_i(1'b0),
      .sum_o(wt_next)
    );

    // Advance the bit weight on every accepted beat.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wt_q <= REM_W'(1);
      end else if (valid_i) begin
        wt_q <= wt_next;
      end
    end
  end

  // Running remainder; idle beats hold it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q <= '0;
    end else if (valid_i) begin
      rem_q <= rem_next;
    end
  end

  // Capture the completed number's result and pulse res_valid for one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_div_q   <= 1'b0;
    end else begin
      res_valid_q <= valid_i & eop_i;
      if (valid_i && eop_i) begin
        res_div_q <= (rem_next == '0);
      end
    end
  end

`ifdef SERIAL_MOD_REM_OUT_EN
  logic [REM_W-1:0] res_rem_q;

  // Captured remainder alongside the divisibility flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_rem_q <= '0;
    end else if (valid_i && eop_i) begin
      res_rem_q <= rem_next;
    end
  end

  assign rem_o     = rem_q;
  assign res_rem_o = res_rem_q;
`endif

  assign div_o       = (rem_q == '0);
  assign res_valid_o = res_valid_q;
  assign res_div_o   = res_div_q;

endmodule

// File: tb/tb_serial_mod_n_checker.sv
// Bench for serial_mod_n_checker: several instances with different divisors and bit orders
// share one stimulus stream; a model holding the whole number value predicts every output.
module tb_serial_mod_n_checker;

  localparam int N = 6;
  localparam int unsigned DIVS [N] = '{3, 5, 7, 8, 255, 2};
  localparam int unsigned MSBS [N] = '{1, 0, 1, 0, 0, 1};

  logic clk = 1'b0;
  logic reset_n;
  logic x, valid, sop, eop;

  logic       div_a [N];
  logic       rv_a  [N];
  logic       rd_a  [N];
`ifdef SERIAL_MOD_REM_OUT_EN
  logic [7:0] rem_a [N];
  logic [7:0] rrem_a[N];
`endif

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int unsigned RW = $clog2(DIVS[g]);
`ifdef SERIAL_MOD_REM_OUT_EN
    logic [RW-1:0] rem_l, rrem_l;
    assign rem_a[g]  = 8'(rem_l);
    assign rrem_a[g] = 8'(rrem_l);
`endif
    serial_mod_n_checker #(
      .DIVISOR  (DIVS[g]),
      .MSB_FIRST(MSBS[g] != 0),
      .REM_W    (RW)
    ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .x_i        (x),
      .valid_i    (valid),
      .sop_i      (sop),
      .eop_i      (eop),
      .div_o      (div_a[g]),
      .res_valid_o(rv_a[g]),
      .res_div_o  (rd_a[g])
`ifdef SERIAL_MOD_REM_OUT_EN
      ,
      .rem_o      (rem_l),
      .res_rem_o  (rrem_l)
`endif
    );
  end

  always #5 clk = ~clk;

  // Reference model: the number itself, reduced with plain % when needed.
  longint unsigned val [N];
  int              nbits;
  logic            exp_div [N];
  logic            exp_rv  [N];
  logic            exp_rd  [N];
  int unsigned     exp_rem [N];
  int unsigned     exp_rrem[N];

  int checks = 0;
  int fails  = 0;

  task automatic model_reset();
    nbits = 0;
    for (int g = 0; g < N; g++) begin
      val[g] = 0; exp_div[g] = 1'b1; exp_rv[g] = 1'b0; exp_rd[g] = 1'b0;
      exp_rem[g] = 0; exp_rrem[g] = 0;
    end
  endtask

  // Drive one beat, clock it, advance the model, leave time at posedge+1.
  task automatic beat(input logic xb, input logic vb, input logic sb, input logic eb);
    int pos;
    longint unsigned r;
    x = xb; valid = vb; sop = sb; eop = eb;
    @(posedge clk);
    pos = sb ? 0 : nbits;
    for (int g = 0; g < N; g++) begin
      exp_rv[g] = 1'b0;
      if (vb) begin
        if (sb) val[g] = 0;
        if (MSBS[g] != 0) val[g] = val[g] * 2 + longint'(xb);
        else              val[g] = val[g] | (longint'(xb) << pos);
        r = val[g] % longint'(DIVS[g]);
        exp_rem[g] = int'(r);
        exp_div[g] = (r == 0);
        if (eb) begin
          exp_rv[g] = 1'b1; exp_rd[g] = (r == 0); exp_rrem[g] = int'(r);
        end
      end
    end
    if (vb) nbits = pos + 1;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; x = 0; valid = 0; sop = 0; eop = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    beat(1'b1, 1'b0, 1'b1, 1'b1);
    for (int g = 0; g < N; g++) begin
      checks += 3;
      if (div_a[g] !== 1'b1) begin fails++; $display("FAIL reset div_o d%0d got %b exp 1", DIVS[g], div_a[g]); end
      if (rv_a[g] !== 1'b0) begin fails++; $display("FAIL reset res_valid_o d%0d got %b exp 0", DIVS[g], rv_a[g]); end
      if (rd_a[g] !== 1'b0) begin fails++; $display("FAIL reset res_div_o d%0d got %b exp 0", DIVS[g], rd_a[g]); end
`ifdef SERIAL_MOD_REM_OUT_EN
      checks += 2;
      if (rem_a[g] !== 8'd0) begin fails++; $display("FAIL reset rem_o d%0d got %0d exp 0", DIVS[g], rem_a[g]); end
      if (rrem_a[g] !== 8'd0) begin fails++; $display("FAIL reset res_rem_o d%0d got %0d exp 0", DIVS[g], rrem_a[g]); end
`endif
    end
  endtask

  task automatic test_msb_d3();
    logic bits [3] = '{1'b1, 1'b1, 1'b0};
    logic divs [3] = '{1'b0, 1'b1, 1'b1};
    int   rems [3] = '{1, 0, 0};
    int   pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) beat(bits[i], 1'b1, i == 0, i == 2);
      else       beat(1'b0, 1'b0, 1'b0, 1'b0);
      if (rv_a[0] === 1'b1) pulses++;
      if (i < 3) begin
        checks++;
        if (div_a[0] !== divs[i]) begin fails++; $display("FAIL msb_d3 div_o beat %0d got %b exp %b", i, div_a[0], divs[i]); end
`ifdef SERIAL_MOD_REM_OUT_EN
        checks++;
        if (rem_a[0] !== 8'(rems[i])) begin fails++; $display("FAIL msb_d3 rem_o beat %0d got %0d exp %0d", i, rem_a[0], rems[i]); end
`endif
      end
      if (i == 2) begin
        checks++;
        if (rd_a[0] !== 1'b1) begin fails++; $display("FAIL msb_d3 res_div_o got %b exp 1", rd_a[0]); end
      end
      for (int g = 0; g < N; g++) begin
        checks += 3;
        if (div_a[g] !== exp_div[g]) begin fails++; $display("FAIL msb_d3 model div_o d%0d got %b exp %b", DIVS[g], div_a[g], exp_div[g]); end
        if (rv_a[g] !== exp_rv[g]) begin fails++; $display("FAIL msb_d3 model res_valid_o d%0d got %b exp %b", DIVS[g], rv_a[g], exp_rv[g]); end
        if (rd_a[g] !== exp_rd[g]) begin fails++; $display("FAIL msb_d3 model res_div_o d%0d got %b exp %b", DIVS[g], rd_a[g], exp_rd[g]); end
      end
    end
    checks++;
    if (pulses != 1) begin fails++; $display("FAIL msb_d3 pulse count got %0d exp 1", pulses); end
  endtask

  task automatic test_lsb_d5();
    logic num_a [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic num_b [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < 4; i++) begin
        beat(n == 0 ? num_a[i] : num_b[i], 1'b1, i == 0, i == 3);
        for (int g = 0; g < N; g++) begin
          checks += 3;
          if (div_a[g] !== exp_div[g]) begin fails++; $display("FAIL lsb_d5 model div_o d%0d got %b exp %b", DIVS[g], div_a[g], exp_div[g]); end
          if (rv_a[g] !== exp_rv[g]) begin fails++; $display("FAIL lsb_d5 model res_valid_o d%0d got %b exp %b", DIVS[g], rv_a[g], exp_rv[g]); end
          if (rd_a[g] !== exp_rd[g]) begin fails++; $display("FAIL lsb_d5 model res_div_o d%0d got %b exp %b", DIVS[g], rd_a[g], exp_rd[g]); end
        end
      end
      checks += 2;
      if (rv_a[1] !== 1'b1) begin fails++; $display("FAIL lsb_d5 res_valid_o num %0d got %b exp 1", n, rv_a[1]); end
      if (rd_a[1] !== (n == 1)) begin fails++; $display("FAIL lsb_d5 res_div_o num %0d got %b exp %b", n, rd_a[1], n == 1); end
`ifdef SERIAL_MOD_REM_OUT_EN
      checks++;
      if (rrem_a[1] !== (n == 0 ? 8'd2 : 8'd0)) begin fails++; $display("FAIL lsb_d5 res_rem_o num %0d got %0d", n, rrem_a[1]); end
`endif
    end
  endtask

  task automatic test_valid_gaps_d7();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) beat(1'b1, 1'b1, i == 0, i == 6);
      else            beat(1'($urandom), 1'b0, 1'($urandom), 1'($urandom));
      for (int g = 0; g < N; g++) begin
        checks += 3;
        if (div_a[g] !== exp_div[g]) begin fails++; $display("FAIL gaps_d7 model div_o d%0d got %b exp %b", DIVS[g], div_a[g], exp_div[g]); end
        if (rv_a[g] !== exp_rv[g]) begin fails++; $display("FAIL gaps_d7 model res_valid_o d%0d got %b exp %b", DIVS[g], rv_a[g], exp_rv[g]); end
        if (rd_a[g] !== exp_rd[g]) begin fails++; $display("FAIL gaps_d7 model res_div_o d%0d got %b exp %b", DIVS[g], rd_a[g], exp_rd[g]); end
`ifdef SERIAL_MOD_REM_OUT_EN
        checks++;
        if (rem_a[g] !== 8'(exp_rem[g])) begin fails++; $display("FAIL gaps_d7 model rem_o d%0d got %0d exp %0d", DIVS[g], rem_a[g], exp_rem[g]); end
`endif
      end
      if (i == 6) begin
        checks++;
        if (rd_a[2] !== 1'b0) begin fails++; $display("FAIL gaps_d7 res_div_o got %b exp 0", rd_a[2]); end
`ifdef SERIAL_MOD_REM_OUT_EN
        checks++;
        if (rrem_a[2] !== 8'd1) begin fails++; $display("FAIL gaps_d7 res_rem_o got %0d exp 1", rrem_a[2]); end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      beat(i == 1, 1'b1, 1'b1, 1'b1);
      for (int g = 0; g < N; g++) begin
        checks += 3;
        if (rv_a[g] !== 1'b1) begin fails++; $display("FAIL b2b res_valid_o d%0d beat %0d got %b exp 1", DIVS[g], i, rv_a[g]); end
        if (rd_a[g] !== (i == 0)) begin fails++; $display("FAIL b2b res_div_o d%0d beat %0d got %b exp %b", DIVS[g], i, rd_a[g], i == 0); end
        if (div_a[g] !== exp_div[g]) begin fails++; $display("FAIL b2b model div_o d%0d got %b exp %b", DIVS[g], div_a[g], exp_div[g]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    beat(1'b0, 1'b1, 1'b1, 1'b1);
    beat(1'b1, 1'b1, 1'b1, 1'b0);
    beat(1'b0, 1'b1, 1'b0, 1'b0);
    beat(1'b1, 1'b0, 1'b0, 1'b0);
    valid = 1'b1; x = 1'b1; eop = 1'b1; sop = 1'b0;
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int g = 0; g < N; g++) begin
      checks += 3;
      if (div_a[g] !== 1'b1) begin fails++; $display("FAIL rst_mid div_o d%0d got %b exp 1", DIVS[g], div_a[g]); end
      if (rv_a[g] !== 1'b0) begin fails++; $display("FAIL rst_mid res_valid_o d%0d got %b exp 0", DIVS[g], rv_a[g]); end
      if (rd_a[g] !== 1'b0) begin fails++; $display("FAIL rst_mid res_div_o d%0d got %b exp 0", DIVS[g], rd_a[g]); end
`ifdef SERIAL_MOD_REM_OUT_EN
      checks += 2;
      if (rem_a[g] !== 8'd0) begin fails++; $display("FAIL rst_mid rem_o d%0d got %0d exp 0", DIVS[g], rem_a[g]); end
      if (rrem_a[g] !== 8'd0) begin fails++; $display("FAIL rst_mid res_rem_o d%0d got %0d exp 0", DIVS[g], rrem_a[g]); end
`endif
    end
    @(posedge clk);
    #1;
    valid = 1'b0; eop = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      beat(1'b0, 1'b0, 1'b0, 1'b0);
      for (int g = 0; g < N; g++) begin
        checks++;
        if (rv_a[g] !== 1'b0) begin fails++; $display("FAIL rst_mid stray pulse d%0d got %b exp 0", DIVS[g], rv_a[g]); end
      end
    end
  endtask

  task automatic test_random();
    logic vb, sb;
    for (int i = 0; i < 3000; i++) begin
      vb = ($urandom_range(3) != 0);
      sb = ($urandom_range(9) == 0);
      if (nbits >= 56) begin vb = 1'b1; sb = 1'b1; end
      beat(1'($urandom), vb, sb, $urandom_range(5) == 0);
      for (int g = 0; g < N; g++) begin
        checks += 3;
        if (div_a[g] !== exp_div[g]) begin fails++; $display("FAIL random div_o d%0d it %0d got %b exp %b", DIVS[g], i, div_a[g], exp_div[g]); end
        if (rv_a[g] !== exp_rv[g]) begin fails++; $display("FAIL random res_valid_o d%0d it %0d got %b exp %b", DIVS[g], i, rv_a[g], exp_rv[g]); end
        if (rd_a[g] !== exp_rd[g]) begin fails++; $display("FAIL random res_div_o d%0d it %0d got %b exp %b", DIVS[g], i, rd_a[g], exp_rd[g]); end
`ifdef SERIAL_MOD_REM_OUT_EN
        checks += 2;
        if (rem_a[g] !== 8'(exp_rem[g])) begin fails++; $display("FAIL random rem_o d%0d it %0d got %0d exp %0d", DIVS[g], i, rem_a[g], exp_rem[g]); end
        if (rrem_a[g] !== 8'(exp_rrem[g])) begin fails++; $display("FAIL random res_rem_o d%0d it %0d got %0d exp %0d", DIVS[g], i, rrem_a[g], exp_rrem[g]); end
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_d3();
    test_lsb_d5();
    test_valid_gaps_d7();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/serial_mod_n_checker.md
# serial_mod_n_checker

Bit-serial divisibility checker, the parametrised successor of the divide-by-3 detector. It accepts a binary number one bit per valid beat, either MSB-first or LSB-first, and keeps a running remainder modulo DIVISOR. It also captures a per-number result on an end-of-number marker. It sits behind serial line receivers and bit-stream parsers that need to flag numbers divisible by a constant without deserialising them.

## Interface
- DIVISOR, 3, modulus; legal range 2..255.
- MSB_FIRST, 1, 1 = bits arrive most-significant first; 0 = least-significant first.
- REM_W, $clog2(DIVISOR), derived remainder width; not overridden by instantiators.
- clk  input  1  clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x_i  input  1  serial data bit.
- valid_i  input  1  x_i, sop_i and eop_i are consumed only when this is 1.
- sop_i  input  1  first bit of a new number; discards prior accumulation.
- eop_i  input  1  last bit of the current number; the result is captured.
- div_o  output  1  running flag; 1 when the accumulated remainder is 0.
- res_valid_o  output  1  one-cycle pulse; a new captured result is available.
- res_div_o  output  1  captured divisibility of the last completed number; held until the next capture.
- rem_o  output  REM_W  running remainder (only with macro, see Configuration).
- res_rem_o  output  REM_W  captured remainder (only with macro).

## Operation
- State:
  - rem_q (REM_W), running remainder.
  - wt_q (REM_W), 2^k mod DIVISOR; used only when MSB_FIRST=0.
  - res_div_q, captured divisibility result.
  - res_rem_q, captured remainder.
  - res_valid_q, result-available pulse.
- On every accepted beat (valid_i=1):
  - base = sop_i ? 0 : rem_q.
  - w = sop_i ? 1 : wt_q.
- MSB-first update: rem_q <= (2*base + x_i) mod DIVISOR.
- LSB-first update:
  - rem_q <= (base + (x_i ? w : 0)) mod DIVISOR.
  - wt_q <= (2*w) mod DIVISOR.
- Reduction width rule:
  - Every operand is < DIVISOR, so every intermediate sum is < 2*DIVISOR.
  - Reduction is therefore one compare plus one conditional subtract at REM_W+1 bits. No divider and no modulo operator.
- When DIVISOR is a power of two, wt_q legitimately reaches 0 in LSB mode and stays 0. No special case is needed.
- Beats where valid_i=0 change no state: x_i, sop_i and eop_i are ignored.
- Before any sop_i, accumulation continues from the reset state: rem_q=0, wt_q=1.
- Capture on an accepted beat with eop_i=1:
  - res_div_q <= (rem_next == 0).
  - res_rem_q <= rem_next.
  - res_valid_q <= 1.
  - On every other cycle res_valid_q <= 0.
- sop_i and eop_i on the same beat denote a 1-bit number; the result is x_i==0 for any DIVISOR >= 2.
- eop_i does not clear rem_q. A following beat without sop_i continues the same number.

## Timing
- Reset values (asynchronous, on reset_n=0):
  - rem_q=0 and wt_q=1, so div_o=1 (an empty number is 0).
  - res_valid_o=0, res_div_o=0, res_rem_o=0.
- Reset mid-number abandons the number. No result pulse is produced for it.
- div_o and rem_o are registered: they reflect all beats accepted up to and including the previous rising edge (1-cycle latency).
- res_valid_o rises in the cycle after the eop beat's edge and lasts exactly one cycle.
- Back-to-back eop beats produce back-to-back pulses, each carrying its own number's result.
- Full throughput: one bit per clock. There is no backpressure and no ready output.

## Configuration
- SERIAL_MOD_REM_OUT_EN defined: ports rem_o and res_rem_o exist and are driven from rem_q and res_rem_q.
- Not defined:
  - Both ports are absent.
  - res_rem_q is not implemented.
  - Divisibility behaviour is identical.

## Structure
- Package serial_mod_pkg:
  - DIVISOR legality bounds (MIN_DIVISOR=2, MAX_DIVISOR=255).
  - Function rem_width(divisor).
  - Function mod_reduce(value, divisor), the single conditional subtract.
- Sub-module mod_add_reduce (inputs a, b < DIVISOR; output (a+b) mod DIVISOR):
  - One instance for the remainder update.
  - One instance for the weight update, generated only when MSB_FIRST=0.

## Test plan
- Reset only: after reset_n deasserts, div_o=1, res_valid_o=0, rem_o=0.
- MSB_FIRST=1, DIVISOR=3, bits 1,1,0 (6) with sop on the first beat and eop on the last:
  - res_valid_o pulses once.
  - res_div_o=1.
  - Intermediate rem_o sequence is 1, 0, 0.
- MSB_FIRST=0, DIVISOR=5, bits 1,1,1,0 LSB-first (7):
  - res_div_o=0, res_rem_o=2.
  - Next number 1,0,1,0 (5) with sop gives res_div_o=1.
- DIVISOR=7, valid_i toggling 1/0 every cycle with 15 (1111) MSB-first: idle cycles change nothing; result res_div_o=0, res_rem_o=1.
- Single-beat sop+eop with x_i=0 then x_i=1 on consecutive cycles: two consecutive pulses, with res_div_o=1 then 0.
- Assert reset_n=0 after 3 bits of a number: no pulse for that number; all outputs return to their reset values immediately.
